centroid_tracker: RTL and testbench
===================================

Name: centroid_tracker

Overview:
- Sits directly downstream of the k-means centroid stage.
- Consumes one unordered set of up to 7 ball centroids per k-means completion.
- Matches each centroid to the previous frame's tracks by greedy nearest-neighbour on Manhattan distance, so ball identities stay stable across frames.
- Emits reordered track positions, per-track velocity and lost flags to the pattern/display logic.

Parameters:
- MAX_JUMP, 64: Manhattan distance (pixels) above which a match is flagged lost.
- MAX_BALLS, 7: track slots; fixed to the k-means array size.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset
- centroids_x_in  input  [8:0] x [6:0]  k-means centroid x, 0..319
- centroids_y_in  input  [7:0] x [6:0]  k-means centroid y, 0..179
- num_balls  input  3  active centroid/track count, 0..7
- data_valid_in  input  1  one-cycle pulse: centroid set valid
- tracks_x_out  output  [8:0] x [6:0]  track x by stable ID
- tracks_y_out  output  [7:0] x [6:0]  track y by stable ID
- vel_x_out  output  signed [9:0] x [6:0]  x change since last frame
- vel_y_out  output  signed [8:0] x [6:0]  y change since last frame
- track_lost_out  output  7  per-track flag: match distance > MAX_JUMP
- data_valid_out  output  1  one-cycle pulse: outputs updated
- busy_out  output  1  high while matching
- dropped_out  output  1  one-cycle pulse: input discarded because busy

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous, active-high.
- Reset: all outputs 0; internal initialised flag cleared; stored N_prev = 0; FSM to IDLE.
- FSM IDLE -> LATCH:
  - Triggered by data_valid_in.
  - Input arrays and num_balls (N) are registered in the same edge.
  - busy_out goes high the next cycle.
- LATCH:
  - Condition for re-seed: not initialised, or N != N_prev, or N == 0.
  - If re-seed: tracks = inputs in index order, velocities 0, lost 0. Go to COMMIT.
  - Otherwise: clear the claimed mask, i = 0, j = 0. Go to MATCH.
- MATCH (one candidate per cycle):
  - Each cycle evaluates d = |cx[j] - tx[i]| + |cy[j] - ty[i]|, 10-bit unsigned, for unclaimed j < N.
  - Keep the strict minimum; ties go to the lowest j.
  - After j = N-1: assign best to track i, set claimed[best], i++, j = 0.
  - After i = N-1 completes: go to COMMIT.
  - MATCH lasts exactly N*N cycles.
- COMMIT:
  - For i < N: vel = new - old, sign-extended; tracks <= new; lost[i] = (best_d > MAX_JUMP).
  - Slots i >= N are forced to 0, including velocity and lost.
  - Set initialised; N_prev <= N.
  - Next cycle: data_valid_out = 1 for one cycle, busy_out = 0, return to IDLE.
- Latency, with the data_valid_in cycle as cycle 0:
  - Re-seed path: data_valid_out at cycle 3.
  - Match path: data_valid_out at cycle N*N + 3.
  - Worst case N = 7: cycle 52. Well under one k-means iteration.
- data_valid_in while busy_out = 1: input ignored, dropped_out pulses in that cycle, the running match is unaffected.
- data_valid_in coincident with the data_valid_out cycle: accepted; the FSM is already in IDLE.
- Outputs hold their value between data_valid_out pulses.
- rst_in mid-MATCH: abort immediately to the reset state; no data_valid_out is produced.
- N = 0: re-seed path; all slots zero; data_valid_out still pulses.
- Inputs at index >= N are ignored and never matched.

Decomposition:
- Shared package juggler_pkg holds:
  - MAX_BALLS = 7, FRAME_WIDTH = 320, FRAME_HEIGHT = 180.
  - Typedefs coord_x_t (logic [8:0]), coord_y_t (logic [7:0]), vel_x_t (signed [9:0]), vel_y_t (signed [8:0]).
  - The FSM state enum.
- The k-means stage should migrate to the same package.
- Sub-module manhattan_distance (combinational, two x/y pairs in, 10-bit distance out) is instantiated once in the match datapath and reusable by k-means.

Test Plan:
- First frame after reset, N=3, inputs (10,20),(100,50),(200,150) -> data_valid_out at cycle 3; tracks equal inputs in order; velocities 0; lost 0.
- Second frame, N=3, permuted inputs (202,148),(12,22),(98,55) -> data_valid_out at cycle 12.
  - tracks = (12,22),(98,55),(202,148).
  - vel = (2,2),(-2,5),(2,-2).
  - lost = 0.
- Tie case: track at (50,50); candidates (60,50) and (40,50) -> the lower index, (60,50), is assigned; the other track receives (40,50).
- Large jump, N=1: track (10,10) -> input (200,100); distance 280 > 64 -> track_lost_out[0] = 1; vel = (190,90).
- N changes 3 -> 4 -> re-seed: identity order, velocities 0, latency 3. Then N=0 -> all outputs 0, data_valid_out still pulses.
- data_valid_in pulsed at cycle 5 of a 7-ball match -> dropped_out pulses at cycle 5; original result still arrives at cycle 52. Separately, rst_in at cycle 20 -> all outputs 0, no data_valid_out.

Source files
------------

// File: rtl/juggler_pkg.sv
// Shared types and constants for the juggler vision pipeline
// (k-means centroid stage and centroid tracker).
package juggler_pkg;

  localparam int MAX_BALLS    = 7;
  localparam int FRAME_WIDTH  = 320;
  localparam int FRAME_HEIGHT = 180;

  typedef logic        [8:0] coord_x_t;
  typedef logic        [7:0] coord_y_t;
  typedef logic signed [9:0] vel_x_t;
  typedef logic signed [8:0] vel_y_t;
  typedef logic        [2:0] ball_idx_t;
  typedef logic        [9:0] dist_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_MATCH  = 2'd2,
    ST_COMMIT = 2'd3
  } track_state_t;

endpackage

// File: rtl/manhattan_distance.sv
// Combinational Manhattan distance between two frame coordinates.
// Max result is 319 + 179 = 498, so 10 bits never overflow.
module manhattan_distance
  import juggler_pkg::*;
(
  input  coord_x_t i_ax,
  input  coord_y_t i_ay,
  input  coord_x_t i_bx,
  input  coord_y_t i_by,
  output dist_t    o_dist
);

  logic [8:0] w_dx;
  logic [7:0] w_dy;

  assign w_dx   = (i_ax >= i_bx) ? (i_ax - i_bx) : (i_bx - i_ax);
  assign w_dy   = (i_ay >= i_by) ? (i_ay - i_by) : (i_by - i_ay);
  assign o_dist = {1'b0, w_dx} + {2'b00, w_dy};

endmodule

// File: rtl/centroid_tracker.sv
// Greedy nearest-neighbour tracker: keeps ball identities stable across
// k-means frames and reports per-track velocity and lost flags.
module centroid_tracker
  import juggler_pkg::*;
#(
  parameter int MAX_JUMP = 64
)
(
  input  logic      clk_in,
  input  logic      rst_in,
  input  coord_x_t  centroids_x_in [MAX_BALLS],
  input  coord_y_t  centroids_y_in [MAX_BALLS],
  input  ball_idx_t num_balls,
  input  logic      data_valid_in,
  output coord_x_t  tracks_x_out   [MAX_BALLS],
  output coord_y_t  tracks_y_out   [MAX_BALLS],
  output vel_x_t    vel_x_out      [MAX_BALLS],
  output vel_y_t    vel_y_out      [MAX_BALLS],
  output logic [MAX_BALLS-1:0] track_lost_out,
  output logic      data_valid_out,
  output logic      busy_out,
  output logic      dropped_out
);

  track_state_t r_state, w_next_state;

  coord_x_t  r_cx [MAX_BALLS];
  coord_y_t  r_cy [MAX_BALLS];
  ball_idx_t r_n, r_n_prev;
  logic      r_init, r_reseed;

  ball_idx_t r_i, r_j, r_best_j;
  dist_t     r_best_d;
  logic      r_have;
  logic [MAX_BALLS-1:0] r_claimed;
  ball_idx_t r_assign  [MAX_BALLS];
  dist_t     r_match_d [MAX_BALLS];

  coord_x_t  r_tx [MAX_BALLS];
  coord_y_t  r_ty [MAX_BALLS];
  vel_x_t    r_vx [MAX_BALLS];
  vel_y_t    r_vy [MAX_BALLS];
  logic [MAX_BALLS-1:0] r_lost;
  logic      r_dv_out;

  dist_t     w_d;
  logic      w_reseed, w_take, w_last_i, w_last_j;
  ball_idx_t w_fin_j;
  dist_t     w_fin_d;
  coord_x_t  w_new_x [MAX_BALLS];
  coord_y_t  w_new_y [MAX_BALLS];
  vel_x_t    w_vel_x [MAX_BALLS];
  vel_y_t    w_vel_y [MAX_BALLS];
  logic [MAX_BALLS-1:0] w_lost;

  manhattan_distance u_dist (
    .i_ax   (r_cx[r_j]),
    .i_ay   (r_cy[r_j]),
    .i_bx   (r_tx[r_i]),
    .i_by   (r_ty[r_i]),
    .o_dist (w_d)
  );

  assign w_reseed = !r_init || (r_n != r_n_prev) || (r_n == 3'd0);
  assign w_last_j = (r_j == r_n - 3'd1);
  assign w_last_i = (r_i == r_n - 3'd1);
  // Strict less-than keeps the lowest index on ties.
  assign w_take   = !r_claimed[r_j] && (!r_have || (w_d < r_best_d));
  assign w_fin_j  = w_take ? r_j : r_best_j;
  assign w_fin_d  = w_take ? w_d : r_best_d;

  always_comb begin
    for (int k = 0; k < MAX_BALLS; k++) begin
      w_new_x[k] = r_cx[r_assign[k]];
      w_new_y[k] = r_cy[r_assign[k]];
      w_vel_x[k] = vel_x_t'({1'b0, w_new_x[k]}) - vel_x_t'({1'b0, r_tx[k]});
      w_vel_y[k] = vel_y_t'({1'b0, w_new_y[k]}) - vel_y_t'({1'b0, r_ty[k]});
      w_lost[k]  = (r_match_d[k] > dist_t'(MAX_JUMP));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (data_valid_in) w_next_state = ST_LATCH;
      ST_LATCH:  w_next_state = w_reseed ? ST_COMMIT : ST_MATCH;
      ST_MATCH:  if (w_last_i && w_last_j) w_next_state = ST_COMMIT;
      ST_COMMIT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_n       <= '0;
      r_n_prev  <= '0;
      r_init    <= 1'b0;
      r_reseed  <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_best_j  <= '0;
      r_best_d  <= '0;
      r_have    <= 1'b0;
      r_claimed <= '0;
      r_lost    <= '0;
      r_dv_out  <= 1'b0;
      for (int k = 0; k < MAX_BALLS; k++) begin
        r_cx[k]      <= '0;
        r_cy[k]      <= '0;
        r_assign[k]  <= '0;
        r_match_d[k] <= '0;
        r_tx[k]      <= '0;
        r_ty[k]      <= '0;
        r_vx[k]      <= '0;
        r_vy[k]      <= '0;
      end
    end else begin
      r_dv_out <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (data_valid_in) begin
            r_n <= num_balls;
            for (int k = 0; k < MAX_BALLS; k++) begin
              r_cx[k] <= centroids_x_in[k];
              r_cy[k] <= centroids_y_in[k];
            end
          end
        end
        ST_LATCH: begin
          // Identity assignment doubles as the re-seed mapping.
          r_reseed  <= w_reseed;
          r_claimed <= '0;
          r_i       <= '0;
          r_j       <= '0;
          r_have    <= 1'b0;
          for (int k = 0; k < MAX_BALLS; k++) begin
            r_assign[k]  <= ball_idx_t'(k);
            r_match_d[k] <= '0;
          end
        end
        ST_MATCH: begin
          if (w_last_j) begin
            r_assign[r_i]      <= w_fin_j;
            r_match_d[r_i]     <= w_fin_d;
            r_claimed[w_fin_j] <= 1'b1;
            r_i    <= r_i + 3'd1;
            r_j    <= '0;
            r_have <= 1'b0;
          end else begin
            r_j      <= r_j + 3'd1;
            r_have   <= r_have | w_take;
            r_best_j <= w_fin_j;
            r_best_d <= w_fin_d;
          end
        end
        ST_COMMIT: begin
          for (int k = 0; k < MAX_BALLS; k++) begin
            if (k < int'(r_n)) begin
              r_tx[k]   <= w_new_x[k];
              r_ty[k]   <= w_new_y[k];
              r_vx[k]   <= r_reseed ? '0 : w_vel_x[k];
              r_vy[k]   <= r_reseed ? '0 : w_vel_y[k];
              r_lost[k] <= r_reseed ? 1'b0 : w_lost[k];
            end else begin
              r_tx[k]   <= '0;
              r_ty[k]   <= '0;
              r_vx[k]   <= '0;
              r_vy[k]   <= '0;
              r_lost[k] <= 1'b0;
            end
          end
          r_init   <= 1'b1;
          r_n_prev <= r_n;
          r_dv_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tracks_x_out   = r_tx;
  assign tracks_y_out   = r_ty;
  assign vel_x_out      = r_vx;
  assign vel_y_out      = r_vy;
  assign track_lost_out = r_lost;
  assign data_valid_out = r_dv_out;
  assign busy_out       = (r_state != ST_IDLE);
  assign dropped_out    = data_valid_in && busy_out;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker: re-seed, matching, ties, lost,
// N changes, dropped input and mid-match reset.
module tb_centroid_tracker;
  import juggler_pkg::*;

  logic      clk, rst;
  coord_x_t  cx_in [MAX_BALLS];
  coord_y_t  cy_in [MAX_BALLS];
  ball_idx_t n_in;
  logic      dv_in;
  coord_x_t  tracks_x_out [MAX_BALLS];
  coord_y_t  tracks_y_out [MAX_BALLS];
  vel_x_t    vel_x_out    [MAX_BALLS];
  vel_y_t    vel_y_out    [MAX_BALLS];
  logic [MAX_BALLS-1:0] track_lost_out;
  logic      dv_out, busy_out, dropped_out;

  int vectors = 0;
  int errs    = 0;
  int fx [MAX_BALLS];
  int fy [MAX_BALLS];
  int ex [MAX_BALLS];
  int ey [MAX_BALLS];
  int evx [MAX_BALLS];
  int evy [MAX_BALLS];
  int elost;
  int lat;

  centroid_tracker #(.MAX_JUMP(64)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .centroids_x_in (cx_in),
    .centroids_y_in (cy_in),
    .num_balls      (n_in),
    .data_valid_in  (dv_in),
    .tracks_x_out   (tracks_x_out),
    .tracks_y_out   (tracks_y_out),
    .vel_x_out      (vel_x_out),
    .vel_y_out      (vel_y_out),
    .track_lost_out (track_lost_out),
    .data_valid_out (dv_out),
    .busy_out       (busy_out),
    .dropped_out    (dropped_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < MAX_BALLS; k++) begin
      check($sformatf("%s.tx%0d", tag, k), int'(tracks_x_out[k]), ex[k]);
      check($sformatf("%s.ty%0d", tag, k), int'(tracks_y_out[k]), ey[k]);
      check($sformatf("%s.vx%0d", tag, k), int'(vel_x_out[k]), evx[k]);
      check($sformatf("%s.vy%0d", tag, k), int'(vel_y_out[k]), evy[k]);
    end
    check({tag, ".lost"}, int'(track_lost_out), elost);
  endtask

  // Expected result of a re-seed: inputs in index order, slots >= n zero.
  task automatic exp_reseed(input int n);
    for (int k = 0; k < MAX_BALLS; k++) begin
      ex[k]  = (k < n) ? fx[k] : 0;
      ey[k]  = (k < n) ? fy[k] : 0;
      evx[k] = 0;
      evy[k] = 0;
    end
    elost = 0;
  endtask

  task automatic exp_zero();
    for (int k = 0; k < MAX_BALLS; k++) begin
      ex[k] = 0; ey[k] = 0; evx[k] = 0; evy[k] = 0;
    end
    elost = 0;
  endtask

  // Launch one frame (data_valid_in in cycle 0) and watch up to `bound`
  // cycles for data_valid_out; optional dropped pulse / reset injection.
  task automatic run_frame(input string tag, input int n, input int drop_cyc,
                           input int rst_cyc, input int bound, input int exp_lat);
    @(negedge clk);
    n_in = 3'(n);
    for (int k = 0; k < MAX_BALLS; k++) begin
      cx_in[k] = 9'(fx[k]);
      cy_in[k] = 8'(fy[k]);
    end
    dv_in = 1'b1;
    @(negedge clk);
    lat = -1;
    for (int c = 1; c <= bound; c++) begin
      dv_in = 1'b0;
      rst   = 1'b0;
      if (c == 1) check({tag, ".busy_c1"}, int'(busy_out), 1);
      if (c == drop_cyc) begin
        dv_in = 1'b1;
        n_in  = 3'd2;
        for (int k = 0; k < MAX_BALLS; k++) begin
          cx_in[k] = 9'd300;
          cy_in[k] = 8'd170;
        end
        #1;
        check({tag, ".dropped"}, int'(dropped_out), 1);
      end
      if (c == rst_cyc) rst = 1'b1;
      if (lat < 0 && dv_out === 1'b1) begin
        lat = c;
        check({tag, ".busy_done"}, int'(busy_out), 0);
      end
      @(negedge clk);
      if (lat >= 0) begin
        check({tag, ".dv_width"}, int'(dv_out), 0);
        break;
      end
    end
    dv_in = 1'b0;
    rst   = 1'b0;
    check({tag, ".latency"}, lat, exp_lat);
  endtask

  initial begin
    rst   = 1'b1;
    dv_in = 1'b0;
    n_in  = '0;
    for (int k = 0; k < MAX_BALLS; k++) begin
      cx_in[k] = '0;
      cy_in[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_zero();
    check_state("reset");
    check("reset.dv", int'(dv_out), 0);
    check("reset.busy", int'(busy_out), 0);
    check("reset.dropped", int'(dropped_out), 0);

    // First frame after reset: re-seed.
    fx = '{10, 100, 200, 0, 0, 0, 0};
    fy = '{20, 50, 150, 0, 0, 0, 0};
    run_frame("f1", 3, 0, 0, 20, 3);
    exp_reseed(3);
    check_state("f1");

    // Permuted second frame: 3x3 match.
    fx = '{202, 12, 98, 0, 0, 0, 0};
    fy = '{148, 22, 55, 0, 0, 0, 0};
    run_frame("f2", 3, 0, 0, 30, 12);
    ex  = '{12, 98, 202, 0, 0, 0, 0};
    ey  = '{22, 55, 148, 0, 0, 0, 0};
    evx = '{2, -2, 2, 0, 0, 0, 0};
    evy = '{2, 5, -2, 0, 0, 0, 0};
    elost = 0;
    check_state("f2");

    // Tie: track (50,50) equidistant from (60,50) and (40,50).
    fx = '{50, 30, 0, 0, 0, 0, 0};
    fy = '{50, 50, 0, 0, 0, 0, 0};
    run_frame("tie_seed", 2, 0, 0, 20, 3);
    exp_reseed(2);
    check_state("tie_seed");
    fx = '{60, 40, 0, 0, 0, 0, 0};
    fy = '{50, 50, 0, 0, 0, 0, 0};
    run_frame("tie", 2, 0, 0, 20, 7);
    ex  = '{60, 40, 0, 0, 0, 0, 0};
    ey  = '{50, 50, 0, 0, 0, 0, 0};
    evx = '{10, 10, 0, 0, 0, 0, 0};
    evy = '{0, 0, 0, 0, 0, 0, 0};
    elost = 0;
    check_state("tie");

    // Large jump: distance 280 > 64.
    fx = '{10, 0, 0, 0, 0, 0, 0};
    fy = '{10, 0, 0, 0, 0, 0, 0};
    run_frame("jump_seed", 1, 0, 0, 20, 3);
    exp_reseed(1);
    check_state("jump_seed");
    fx = '{200, 0, 0, 0, 0, 0, 0};
    fy = '{100, 0, 0, 0, 0, 0, 0};
    run_frame("jump", 1, 0, 0, 20, 4);
    exp_zero();
    ex[0] = 200; ey[0] = 100; evx[0] = 190; evy[0] = 90; elost = 1;
    check_state("jump");

    // N changes 3 -> 4 re-seeds; then N = 0 clears everything.
    fx = '{5, 7, 9, 11, 13, 15, 17};
    fy = '{6, 8, 10, 12, 14, 16, 18};
    run_frame("n3", 3, 0, 0, 20, 3);
    exp_reseed(3);
    check_state("n3");
    fx = '{1, 3, 5, 7, 9, 11, 13};
    fy = '{2, 4, 6, 8, 10, 12, 14};
    run_frame("n4", 4, 0, 0, 20, 3);
    exp_reseed(4);
    check_state("n4");
    run_frame("n0", 0, 0, 0, 20, 3);
    exp_zero();
    check_state("n0");

    // Seven balls, then a reversed set moved by (3,1); input dropped at cycle 5.
    for (int k = 0; k < MAX_BALLS; k++) begin
      fx[k] = 20 + 40 * k;
      fy[k] = 10 + 20 * k;
    end
    run_frame("n7_seed", 7, 0, 0, 20, 3);
    exp_reseed(7);
    check_state("n7_seed");
    for (int k = 0; k < MAX_BALLS; k++) begin
      fx[k]  = 20 + 40 * (6 - k) + 3;
      fy[k]  = 10 + 20 * (6 - k) + 1;
      ex[k]  = 20 + 40 * k + 3;
      ey[k]  = 10 + 20 * k + 1;
      evx[k] = 3;
      evy[k] = 1;
    end
    elost = 0;
    run_frame("n7", 7, 5, 0, 80, 52);
    check_state("n7");

    // Reset at cycle 20 of a 7-ball match: no result, everything zero.
    run_frame("rst_mid", 7, 0, 20, 70, -1);
    exp_zero();
    check_state("rst_mid");
    check("rst_mid.busy", int'(busy_out), 0);

    // Tracker restarts cleanly with a re-seed.
    fx = '{10, 100, 200, 0, 0, 0, 0};
    fy = '{20, 50, 150, 0, 0, 0, 0};
    run_frame("post_rst", 3, 0, 0, 20, 3);
    exp_reseed(3);
    check_state("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
